// File: rtl/ahb3_pkg.sv
// Shared AHB-Lite types, response codes and the byte-lane enable helper
// used by the ahb3lite_sram_slave family.
package ahb3_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Lane mask for a (1<<size)-byte access; the offset is aligned down to the size first.
    function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] offset);
        logic [3:0]  nbytes_s;
        logic [2:0]  base_s;
        logic [15:0] mask_s;
        nbytes_s = 4'd1 << size;
        base_s   = offset & ~(nbytes_s[2:0] - 3'd1);
        mask_s   = ((16'd1 << nbytes_s) - 16'd1) << base_s;
        return mask_s[7:0];
    endfunction

endpackage

// File: rtl/ahb3_sram_bank.sv
// DEPTH x DATA_W word array with per-byte write enables and an asynchronous read port.
module ahb3_sram_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic [DATA_W/8-1:0]        we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we[b]) begin
                mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// Parametrised AHB-Lite SRAM slave with programmable wait states and byte-lane writes.
// Define AHB3_ERR_RESP_EN to answer out-of-range/unaligned/oversize transfers with a two-cycle ERROR.
module ahb3lite_sram_slave
    import ahb3_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_HSEL,
    input  logic [ADDR_W-1:0] i_HADDR,
    input  logic              i_HWRITE,
    input  logic [1:0]        i_HTRANS,
    input  logic [2:0]        i_HSIZE,
    input  logic [2:0]        i_HBURST,
    input  logic              i_HREADY,
    input  logic [DATA_W-1:0] i_HWDATA,
    output logic [DATA_W-1:0] o_HRDATA,
    output logic              o_HREADYOUT,
    output logic              o_HRESP
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    state_e              state_r;
    logic [2:0]          cnt_r;
    logic                ready_r;
    logic                resp_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [IDX_W-1:0]    idx_r;
    logic [BYTES-1:0]    be_r;
    logic                wr_r;

    logic [ADDR_W-1:0]   rel_addr_s;
    logic [ADDR_W-1:0]   full_idx_s;
    logic [IDX_W-1:0]    idx_s;
    logic                out_of_range_s;
    logic [2:0]          off3_s;
    logic                oversize_s;
    logic [1:0]          eff_size_s;
    logic [2:0]          size_mask_s;
    logic                unaligned_s;
    logic [7:0]          be8_s;
    logic [BYTES-1:0]    be_s;
    logic                accept_s;
    logic                err_s;
    logic                wr_en_s;
    logic [BYTES-1:0]    bank_we_s;
    logic [IDX_W-1:0]    rd_idx_s;
    logic [DATA_W-1:0]   bank_rdata_s;
    logic [DATA_W-1:0]   bemask_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                unused_s;

    // Address-phase decode: word index, lane enables, range/alignment/size checks.
    always_comb begin
        rel_addr_s     = i_HADDR - BASE_ADDR;
        full_idx_s     = rel_addr_s >> OFF_W;
        idx_s          = full_idx_s[IDX_W-1:0];
        out_of_range_s = |(full_idx_s >> IDX_W);
        off3_s         = 3'(rel_addr_s[OFF_W-1:0]);
        oversize_s     = (i_HSIZE > 3'(OFF_W));
        if (oversize_s) begin
            eff_size_s = 2'(OFF_W);
        end else begin
            eff_size_s = i_HSIZE[1:0];
        end
        size_mask_s = 3'((4'd1 << eff_size_s) - 4'd1);
        unaligned_s = |(off3_s & size_mask_s);
        be8_s       = byte_enable(eff_size_s, off3_s);
        be_s        = be8_s[BYTES-1:0];
        accept_s    = i_HSEL && i_HREADY
                      && ((i_HTRANS == HTRANS_NONSEQ) || (i_HTRANS == HTRANS_SEQ))
                      && (state_r != ST_WAIT) && (state_r != ST_ERR1);
    end

`ifdef AHB3_ERR_RESP_EN
    assign err_s    = out_of_range_s | unaligned_s | oversize_s;
    assign unused_s = ^{i_HBURST, be8_s};
`else
    assign err_s    = 1'b0;
    assign unused_s = ^{i_HBURST, be8_s, out_of_range_s, unaligned_s};
`endif

    // The write of a DATA cycle lands on the same edge that may capture the next read.
    assign wr_en_s   = (state_r == ST_DATA) && wr_r;
    assign bank_we_s = be_r & {BYTES{wr_en_s}};
    assign rd_idx_s  = (WAIT_STATES == 0) ? idx_s : idx_r;

    ahb3_sram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (HCLK),
        .we    (bank_we_s),
        .waddr (idx_r),
        .wdata (i_HWDATA),
        .raddr (rd_idx_s),
        .rdata (bank_rdata_s)
    );

    // Forward the in-flight write lanes into a read of the same word.
    always_comb begin
        bemask_s = '0;
        for (int b = 0; b < BYTES; b++) begin
            bemask_s[b*8 +: 8] = {8{be_r[b]}};
        end
        if (wr_en_s && (idx_r == rd_idx_s)) begin
            rd_word_s = (bank_rdata_s & ~bemask_s) | (i_HWDATA & bemask_s);
        end else begin
            rd_word_s = bank_rdata_s;
        end
    end

    // Transfer FSM with wait counter, control pipeline and registered bus outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            ready_r <= 1'b1;
            resp_r  <= HRESP_OKAY;
            rdata_r <= '0;
            idx_r   <= '0;
            be_r    <= '0;
            wr_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept_s) begin
                        idx_r <= idx_s;
                        be_r  <= be_s;
                        wr_r  <= i_HWRITE;
                        if (err_s) begin
                            state_r <= ST_ERR1;
                            ready_r <= 1'b0;
                            resp_r  <= HRESP_ERROR;
                            rdata_r <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= 3'(WAIT_STATES - 1);
                            ready_r <= 1'b0;
                            resp_r  <= HRESP_OKAY;
                            rdata_r <= '0;
                        end else begin
                            state_r <= ST_DATA;
                            ready_r <= 1'b1;
                            resp_r  <= HRESP_OKAY;
                            rdata_r <= i_HWRITE ? '0 : rd_word_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        resp_r  <= HRESP_OKAY;
                        rdata_r <= '0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_r <= ST_DATA;
                        ready_r <= 1'b1;
                        rdata_r <= wr_r ? '0 : rd_word_s;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state_r <= ST_ERR2;
                    ready_r <= 1'b1;
                    resp_r  <= HRESP_ERROR;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    resp_r  <= HRESP_OKAY;
                    rdata_r <= '0;
                end
            endcase
        end
    end

    assign o_HRDATA    = rdata_r;
    assign o_HREADYOUT = ready_r;
    assign o_HRESP     = resp_r;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: instance 0 with no wait states, instance 1 with two,
// directed table, randomized traffic against a byte-level memory model, reset and error corners.
module tb_ahb3lite_sram_slave;

    typedef struct {
        int          u;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] data;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic        hwrite    [2];
    logic [1:0]  htrans    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic        hready    [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    logic [7:0]  mbytes [2][1024];
    vec_t        tbl[$];
    vec_t        q[$];
    int          n_pass = 0;
    int          n_tot  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign hready[g] = hreadyout[g];
        ahb3lite_sram_slave #(.WAIT_STATES(g * 2)) dut (
            .HCLK        (clk),
            .HRESETn     (rst_n[g]),
            .i_HSEL      (hsel[g]),
            .i_HADDR     (haddr[g]),
            .i_HWRITE    (hwrite[g]),
            .i_HTRANS    (htrans[g]),
            .i_HSIZE     (hsize[g]),
            .i_HBURST    (hburst[g]),
            .i_HREADY    (hready[g]),
            .i_HWDATA    (hwdata[g]),
            .o_HRDATA    (hrdata[g]),
            .o_HREADYOUT (hreadyout[g]),
            .o_HRESP     (hresp[g])
        );
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic int word_of(logic [31:0] addr);
        return int'((addr >> 2) % 32'd256);
    endfunction

    function automatic logic [31:0] model_read(int u, logic [31:0] addr);
        int w;
        w = word_of(addr);
        return {mbytes[u][w*4+3], mbytes[u][w*4+2], mbytes[u][w*4+1], mbytes[u][w*4]};
    endfunction

    function automatic void model_write(int u, vec_t t);
        int n, w, lane0;
        n     = 1 << ((t.size > 3'd2) ? 2 : int'(t.size));
        w     = word_of(t.addr);
        lane0 = (int'(t.addr % 32'd4) / n) * n;
        for (int k = 0; k < n; k++) mbytes[u][w*4+lane0+k] = t.data[(lane0+k)*8 +: 8];
    endfunction

    function automatic void add(int u, bit wr, logic [31:0] addr, logic [2:0] size, logic [1:0] trans,
                                logic [2:0] burst, logic [31:0] data, bit chk, logic [31:0] exp);
        vec_t v;
        v.u = u; v.wr = wr; v.addr = addr; v.size = size; v.trans = trans;
        v.burst = burst; v.data = data; v.chk = chk; v.exp = exp;
        tbl.push_back(v);
    endfunction

    // Pipelined master: issues queue q on unit u, checks each data phase on completion.
    task automatic run(input int u);
        int   i = 0;
        int   wcnt = 0;
        int   guard = 0;
        bit   pend = 1'b0;
        bit   issued;
        vec_t p;
        vec_t nx;
        while ((i < q.size() || pend) && guard < 20000) begin
            guard++;
            if (pend) begin
                if (hreadyout[u]) begin
                    check($sformatf("u%0d waits @%h", u, p.addr), 64'(wcnt), 64'((u == 1) ? 2 : 0));
                    check($sformatf("u%0d resp @%h", u, p.addr), 64'(hresp[u]), 64'd0);
                    if (p.wr) begin
                        model_write(u, p);
                    end else begin
                        check($sformatf("u%0d rd @%h", u, p.addr), 64'(hrdata[u]), 64'(model_read(u, p.addr)));
                        if (p.chk) check($sformatf("u%0d tbl rd @%h", u, p.addr), 64'(hrdata[u]), 64'(p.exp));
                    end
                    pend = 1'b0;
                end else begin
                    wcnt++;
                end
            end
            issued = 1'b0;
            if (hreadyout[u]) begin
                if (i < q.size()) begin
                    nx = q[i];
                    i++;
                    hsel[u] = 1'b1; haddr[u] = nx.addr; hwrite[u] = nx.wr;
                    htrans[u] = nx.trans; hsize[u] = nx.size; hburst[u] = nx.burst;
                    issued = nx.trans[1];
                end else begin
                    hsel[u] = 1'b0; htrans[u] = 2'd0;
                end
            end
            @(posedge clk); #1;
            if (issued) begin
                p = nx; pend = 1'b1; wcnt = 0; hwdata[u] = nx.data;
            end
        end
        check($sformatf("u%0d sequence timeout", u), 64'(guard < 20000), 64'd1);
        q.delete();
        hsel[u] = 1'b0; htrans[u] = 2'd0;
    endtask

    initial begin
        vec_t v;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; hsel[u] = 1'b0; haddr[u] = 32'd0; hwrite[u] = 1'b0;
            htrans[u] = 2'd0; hsize[u] = 3'd2; hburst[u] = 3'd0; hwdata[u] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d reset readyout", u), 64'(hreadyout[u]), 64'd1);
            check($sformatf("u%0d reset resp", u), 64'(hresp[u]), 64'd0);
            check($sformatf("u%0d reset rdata", u), 64'(hrdata[u]), 64'd0);
            rst_n[u] = 1'b1;
        end
        @(posedge clk); #1;

        // Give every word a known value so any later read has a model answer.
        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 256; w++) begin
                v.u = u; v.wr = 1'b1; v.addr = 32'(w * 4); v.size = 3'd2; v.trans = 2'd2;
                v.burst = 3'd0; v.data = $urandom; v.chk = 1'b0; v.exp = 32'd0;
                q.push_back(v);
            end
            run(u);
        end

        add(1, 1'b1, 32'h10, 3'd2, 2'd2, 3'd0, 32'hDEADBEEF, 1'b0, 32'd0);
        add(1, 1'b0, 32'h10, 3'd2, 2'd2, 3'd0, 32'd0, 1'b1, 32'hDEADBEEF);
        add(1, 1'b1, 32'h08, 3'd2, 2'd2, 3'd0, 32'h55, 1'b0, 32'd0);
        add(1, 1'b0, 32'h08, 3'd2, 2'd2, 3'd0, 32'd0, 1'b1, 32'h55);
        add(0, 1'b1, 32'h20, 3'd2, 2'd2, 3'd0, 32'h0, 1'b0, 32'd0);
        add(0, 1'b1, 32'h21, 3'd0, 2'd2, 3'd0, 32'hABABABAB, 1'b0, 32'd0);
        add(0, 1'b0, 32'h20, 3'd2, 2'd2, 3'd0, 32'd0, 1'b1, 32'h0000AB00);
        for (int k = 0; k < 4; k++)
            add(0, 1'b1, 32'(32'h40 + k * 4), 3'd2, (k == 0) ? 2'd2 : 2'd3, 3'd3, 32'(k + 1), 1'b0, 32'd0);
        for (int k = 0; k < 4; k++)
            add(0, 1'b0, 32'(32'h40 + k * 4), 3'd2, (k == 0) ? 2'd2 : 2'd3, 3'd3, 32'd0, 1'b1, 32'(k + 1));
        add(0, 1'b1, 32'h08, 3'd2, 2'd2, 3'd0, 32'h55, 1'b0, 32'd0);
        add(0, 1'b0, 32'h08, 3'd2, 2'd2, 3'd0, 32'd0, 1'b1, 32'h55);
`ifndef AHB3_ERR_RESP_EN
        add(0, 1'b1, 32'h00, 3'd2, 2'd2, 3'd0, 32'h12345678, 1'b0, 32'd0);
        add(0, 1'b0, 32'h400, 3'd2, 2'd2, 3'd0, 32'd0, 1'b1, 32'h12345678);
        add(0, 1'b1, 32'h62, 3'd2, 2'd2, 3'd0, 32'hCAFEF00D, 1'b0, 32'd0);
        add(0, 1'b0, 32'h60, 3'd2, 2'd2, 3'd0, 32'd0, 1'b1, 32'hCAFEF00D);
        add(0, 1'b1, 32'h70, 3'd3, 2'd2, 3'd0, 32'h0BADC0DE, 1'b0, 32'd0);
        add(0, 1'b0, 32'h70, 3'd2, 2'd2, 3'd0, 32'd0, 1'b1, 32'h0BADC0DE);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            q.push_back(tbl[i]);
            if (i == tbl.size() - 1 || tbl[i+1].u != tbl[i].u) run(tbl[i].u);
        end

        // Randomized aligned in-range traffic with occasional idle slots.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 300; n++) begin
                v.u = u; v.wr = 1'($urandom_range(0, 1)); v.size = 3'($urandom_range(0, 2));
                v.addr = 32'($urandom_range(0, 1023)) & ~((32'd1 << v.size) - 32'd1);
                v.trans = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'd2; v.burst = 3'd1;
                v.data = $urandom; v.chk = 1'b0; v.exp = 32'd0;
                q.push_back(v);
            end
            run(u);
        end

        // Reset asserted while a write sits in its wait states: nothing may be committed.
        haddr[1] = 32'h30; hwrite[1] = 1'b1; hsize[1] = 3'd2; htrans[1] = 2'd2; hsel[1] = 1'b1;
        @(posedge clk); #1;
        hwdata[1] = 32'hFFFF_FFFF; hsel[1] = 1'b0; htrans[1] = 2'd0;
        check("u1 in wait before reset", 64'(hreadyout[1]), 64'd0);
        rst_n[1] = 1'b0;
        #1;
        check("u1 async reset readyout", 64'(hreadyout[1]), 64'd1);
        check("u1 async reset resp", 64'(hresp[1]), 64'd0);
        check("u1 async reset rdata", 64'(hrdata[1]), 64'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        v.u = 1; v.wr = 1'b0; v.addr = 32'h30; v.size = 3'd2; v.trans = 2'd2;
        v.burst = 3'd0; v.data = 32'd0; v.chk = 1'b0; v.exp = 32'd0;
        q.push_back(v);
        run(1);

`ifdef AHB3_ERR_RESP_EN
        haddr[0] = 32'h400; hwrite[0] = 1'b0; hsize[0] = 3'd2; htrans[0] = 2'd2; hsel[0] = 1'b1;
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'd0;
        check("err1 readyout", 64'(hreadyout[0]), 64'd0);
        check("err1 resp", 64'(hresp[0]), 64'd1);
        @(posedge clk); #1;
        check("err2 readyout", 64'(hreadyout[0]), 64'd1);
        check("err2 resp", 64'(hresp[0]), 64'd1);
        check("err2 rdata", 64'(hrdata[0]), 64'd0);
        @(posedge clk); #1;
        check("after err resp", 64'(hresp[0]), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
